// File: rtl/pomdp_pkg.sv
// Shared types and helpers for the POMDP belief-tracking slice.
// Holds the Q0.16 probability type, model dimensions, the initial belief,
// the belief-update FSM encoding and small fixed-point arithmetic helpers.
package pomdp_pkg;

  typedef logic [15:0] q16_t;

  localparam int NUM_ACTIONS = 3;
  localparam int NUM_STATES  = 2;
  localparam int NUM_OBS     = 2;

  localparam q16_t BELIEF_HALF = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRED = 3'd1,
    ST_LIKE = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } belief_state_e;

  // Full 32-bit product of two Q0.16 values.
  function automatic logic [31:0] mul32(input q16_t a, input q16_t b);
    return {16'h0000, a} * {16'h0000, b};
  endfunction

  // Drop the 16 fraction bits of a 33-bit sum and clamp anything above 0xFFFF.
  function automatic q16_t sat16(input logic [32:0] sum);
    logic [32:0] sh;
    sh = sum >> 16;
    if (sh > 33'h0_FFFF) begin
      return 16'hFFFF;
    end else begin
      return 16'(sh);
    end
  endfunction

  // Upper half of a Q0.16 x Q0.16 product (truncating).
  function automatic q16_t mul_hi(input q16_t a, input q16_t b);
    return 16'(mul32(a, b) >> 16);
  endfunction

endpackage

// File: rtl/q16_div.sv
// Iterative restoring divider producing a 17-bit floor quotient.
// One quotient bit is resolved per clock; DIV_ITERS steps follow a start.
// The caller guarantees dividend >> 17 < divisor, so 17 bits hold the quotient.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load dividend/divisor and begin (one-cycle pulse)
//   dividend    33-bit dividend
//   divisor     17-bit divisor (non-zero), latched on start
//   done        high during the cycle whose closing edge performs the last step
//   quotient    quotient register; final after the edge on which done is high
module q16_div #(
  parameter int DIV_ITERS = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [32:0] dividend,
  input  logic [16:0] divisor,
  output logic        done,
  output logic [16:0] quotient
);

  logic [16:0] rem_r;
  logic [16:0] quo_r;
  logic [16:0] div_r;
  logic [4:0]  cnt_r;

  logic [17:0] shifted_s;
  logic [18:0] diff_s;
  logic [16:0] rem_next_s;
  logic [16:0] quo_next_s;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    shifted_s = {rem_r, quo_r[16]};
    diff_s    = {1'b0, shifted_s} - {2'b00, div_r};
    if (diff_s[18]) begin
      rem_next_s = 17'(shifted_s);
    end else begin
      rem_next_s = 17'(diff_s);
    end
    quo_next_s = {quo_r[15:0], ~diff_s[18]};
  end

  // Divider state: load on start, otherwise step until the count runs out.
  // The low dividend bits share the quotient register and are shifted out
  // as quotient bits are shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= 17'd0;
      quo_r <= 17'd0;
      div_r <= 17'd0;
      cnt_r <= 5'd0;
    end else if (start) begin
      rem_r <= {1'b0, dividend[32:17]};
      quo_r <= dividend[16:0];
      div_r <= divisor;
      cnt_r <= 5'(DIV_ITERS);
    end else if (cnt_r != 5'd0) begin
      rem_r <= rem_next_s;
      quo_r <= quo_next_s;
      cnt_r <= cnt_r - 5'd1;
    end
  end

  assign done     = (cnt_r == 5'd1);
  assign quotient = quo_r;

endmodule

// File: rtl/belief_update.sv
// Bayes-filter update of a 2-state belief (Q0.16 probability of state 0).
// On en_belief the captured action/observation drive a predict step through
// the transition table, a likelihood step through the observation table and
// a normalising division. Degenerate updates (zero evidence or action 3)
// leave the belief untouched and flag err.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en_belief     start pulse, honoured only when idle and not busy
//   observation   observed symbol o
//   action        action a (0..2 valid)
//   trans         T[a][s][s'], must stay stable while busy
//   observe       O[a][s'][o], must stay stable while busy
//   belief_load   synchronous load of belief_init, aborts any update
//   belief_init   belief value loaded by belief_load
//   belief        current P(state 0)
//   belief_valid  one-cycle pulse when an update finishes
//   busy          update in progress (through the belief_valid cycle)
//   err           one-cycle pulse with belief_valid on a degenerate update
module belief_update
  import pomdp_pkg::*;
#(
  parameter int W         = 16,
  parameter int DIV_ITERS = 17
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 en_belief,
  input  logic                                                 observation,
  input  logic [1:0]                                           action,
  input  logic [0:NUM_ACTIONS-1][0:NUM_STATES-1][0:NUM_STATES-1][W-1:0] trans,
  input  logic [0:NUM_ACTIONS-1][0:NUM_STATES-1][0:NUM_OBS-1][W-1:0]    observe,
  input  logic                                                 belief_load,
  input  logic [W-1:0]                                         belief_init,
  output logic [W-1:0]                                         belief,
  output logic                                                 belief_valid,
  output logic                                                 busy,
  output logic                                                 err
);

  belief_state_e state_r;
  logic [1:0]    act_r;
  logic          obs_r;
  q16_t          belief_r;
  logic          valid_r;
  logic          busy_r;
  logic          err_r;
  logic          degen_r;
  q16_t          p0_r;
  q16_t          p1_r;

  logic [1:0]    act_idx_s;
  q16_t          b0_s;
  q16_t          b1_s;
  logic [32:0]   pred0_sum_s;
  logic [32:0]   pred1_sum_s;
  q16_t          u0_s;
  q16_t          u1_s;
  logic [16:0]   d_s;
  logic          degen_s;
  logic          div_start_s;
  logic          div_done_s;
  logic [16:0]   quotient_s;

  // Predict and likelihood datapath; action 3 is remapped to a legal table
  // index so nothing reads out of range (its result is discarded anyway).
  always_comb begin
    if (act_r == 2'd3) begin
      act_idx_s = 2'd0;
    end else begin
      act_idx_s = act_r;
    end
    b0_s = belief_r;
    b1_s = 16'hFFFF - belief_r;
    pred0_sum_s = {1'b0, mul32(trans[act_idx_s][0][0], b0_s)}
                + {1'b0, mul32(trans[act_idx_s][1][0], b1_s)};
    pred1_sum_s = {1'b0, mul32(trans[act_idx_s][0][1], b0_s)}
                + {1'b0, mul32(trans[act_idx_s][1][1], b1_s)};
    u0_s    = mul_hi(p0_r, observe[act_idx_s][0][obs_r]);
    u1_s    = mul_hi(p1_r, observe[act_idx_s][1][obs_r]);
    d_s     = {1'b0, u0_s} + {1'b0, u1_s};
    degen_s = (d_s == 17'd0) || (act_r == 2'd3);
    if ((state_r == ST_LIKE) && !belief_load && !degen_s) begin
      div_start_s = 1'b1;
    end else begin
      div_start_s = 1'b0;
    end
  end

  q16_div #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .dividend ({1'b0, u0_s, 16'h0000}),
    .divisor  (d_s),
    .done     (div_done_s),
    .quotient (quotient_s)
  );

  // Update FSM and belief register; belief_load overrides every state.
  // busy stays high through the belief_valid cycle and drops on the next
  // edge, so a start is honoured only once busy has cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      act_r    <= 2'd0;
      obs_r    <= 1'b0;
      belief_r <= BELIEF_HALF;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
      degen_r  <= 1'b0;
      p0_r     <= 16'h0000;
      p1_r     <= 16'h0000;
    end else if (belief_load) begin
      state_r  <= ST_IDLE;
      belief_r <= belief_init;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
      degen_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_r <= 1'b0;
          err_r   <= 1'b0;
          if (en_belief && !busy_r) begin
            act_r   <= action;
            obs_r   <= observation;
            busy_r  <= 1'b1;
            state_r <= ST_PRED;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_PRED: begin
          p0_r    <= sat16(pred0_sum_s);
          p1_r    <= sat16(pred1_sum_s);
          state_r <= ST_LIKE;
        end
        ST_LIKE: begin
          degen_r <= degen_s;
          if (degen_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!degen_r) begin
            // u0 <= d, so only the exact-1.0 quotient 0x10000 overflows.
            if (quotient_s[16]) begin
              belief_r <= 16'hFFFF;
            end else begin
              belief_r <= quotient_s[15:0];
            end
          end
          err_r   <= degen_r;
          valid_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign belief       = belief_r;
  assign belief_valid = valid_r;
  assign busy         = busy_r;
  assign err          = err_r;

endmodule

// File: tb/tb_belief_update.sv
// Self-checking bench for belief_update: a table of update vectors plus
// hand-written sequences for busy handling, mid-update load and reset.
// Expected results are queued at start and compared when belief_valid fires.
module tb_belief_update;

  typedef logic [0:2][0:1][0:1][15:0] tab_t;

  typedef struct {
    logic [1:0]  a;
    logic        o;
    logic [15:0] init;
    logic [15:0] t00, t01, t10, t11;
    logic [15:0] o0, o1;
    logic [15:0] exp_b;
    logic        exp_e;
    logic        use_model;
  } vec_t;

  typedef struct {
    logic [15:0] b;
    logic        e;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_belief;
  logic        observation;
  logic [1:0]  action;
  tab_t        trans;
  tab_t        observe;
  logic        belief_load;
  logic [15:0] belief_init;
  logic [15:0] belief;
  logic        belief_valid;
  logic        busy;
  logic        err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   valid_seen = 0;
  exp_t sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  belief_update dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_belief    (en_belief),
    .observation  (observation),
    .action       (action),
    .trans        (trans),
    .observe      (observe),
    .belief_load  (belief_load),
    .belief_init  (belief_init),
    .belief       (belief),
    .belief_valid (belief_valid),
    .busy         (busy),
    .err          (err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference Bayes update computed with wide integer arithmetic.
  function automatic void model(input logic [1:0] a, input logic o, input logic [15:0] b,
                                input tab_t t, input tab_t ob,
                                output logic [15:0] nb, output logic e);
    longint b0, b1, p0, p1, u0, u1, d, q;
    nb = b;
    e  = 1'b1;
    if (a == 2'd3) return;
    b0 = longint'(b);
    b1 = 65535 - b0;
    p0 = (longint'(t[a][0][0]) * b0 + longint'(t[a][1][0]) * b1) / 65536;
    p1 = (longint'(t[a][0][1]) * b0 + longint'(t[a][1][1]) * b1) / 65536;
    if (p0 > 65535) p0 = 65535;
    if (p1 > 65535) p1 = 65535;
    u0 = (p0 * longint'(ob[a][0][o])) / 65536;
    u1 = (p1 * longint'(ob[a][1][o])) / 65536;
    d  = u0 + u1;
    if (d == 0) return;
    q = (u0 * 65536) / d;
    if (q > 65535) q = 65535;
    nb = 16'(q);
    e  = 1'b0;
  endfunction

  // Advance one cycle and score any completed update.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    cyc++;
    if (belief_valid) begin
      valid_seen++;
      check("busy_with_valid", busy, 1);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got belief_valid=1 at cycle %0d expected 0", cyc);
      end else begin
        x = sb.pop_front();
        check("belief", belief, x.b);
        check("err", err, x.e);
        check("latency", cyc, x.lat);
      end
    end else if (err) begin
      checks++;
      failures++;
      $display("FAIL err_without_valid: got err=1 at cycle %0d expected 0", cyc);
    end
  endtask

  // Called at a negedge; the following posedge is E0.
  task automatic start(input logic [1:0] a, input logic o, input logic [15:0] eb, input logic ee);
    exp_t x;
    x.b = eb;
    x.e = ee;
    x.lat = ee ? 3 : 20;
    sb.push_back(x);
    en_belief   = 1'b1;
    action      = a;
    observation = o;
    @(negedge clk);
    en_belief = 1'b0;
    cyc = 0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int maxc);
    int v0;
    v0 = valid_seen;
    while (valid_seen == v0 && cyc < maxc) tick();
    check("completed_in_time", (valid_seen != v0), 1);
    tick();
    check("busy_cleared", busy, 0);
    check("valid_one_cycle", belief_valid, 0);
  endtask

  task automatic do_load(input logic [15:0] v);
    belief_load = 1'b1;
    belief_init = v;
    @(negedge clk);
    belief_load = 1'b0;
    check("load_value", belief, v);
  endtask

  task automatic set_tiger();
    trans   = '0;
    observe = '0;
    trans[0][0][0]   = 16'hFFFF;
    trans[0][1][1]   = 16'hFFFF;
    observe[0][0][0] = 16'hD999;
    observe[0][1][0] = 16'h2666;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] eb;
    logic        ee;
    int          v0;

    rst_n = 1'b0; en_belief = 1'b0; observation = 1'b0; action = 2'd0;
    trans = '0; observe = '0; belief_load = 1'b0; belief_init = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("reset_belief", belief, 16'h8000);
    check("reset_valid", belief_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    //          a     o     init      t00       t01       t10       t11       o0        o1        exp_b     e     model
    vecs[0] = '{2'd0, 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hD999, 16'h2666, 16'hD99B, 1'b0, 1'b0};
    vecs[1] = '{2'd0, 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hD999, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    vecs[2] = '{2'd0, 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 1'b1, 1'b0};
    vecs[3] = '{2'd3, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0};
    vecs[4] = '{2'd0, 1'b1, 16'hD99B, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h2666, 16'hD999, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{2'd1, 1'b0, 16'h3000, 16'hC000, 16'h4000, 16'h2000, 16'hE000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{2'd2, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h1000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
    vecs[7] = '{2'd2, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{2'd1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      for (int a = 0; a < 3; a++)
        for (int s = 0; s < 2; s++)
          for (int k = 0; k < 2; k++) begin
            trans[a][s][k]   = 16'($urandom);
            observe[a][s][k] = 16'($urandom);
          end
      if (vecs[i].a != 2'd3) begin
        trans[vecs[i].a][0][0] = vecs[i].t00;
        trans[vecs[i].a][0][1] = vecs[i].t01;
        trans[vecs[i].a][1][0] = vecs[i].t10;
        trans[vecs[i].a][1][1] = vecs[i].t11;
        observe[vecs[i].a][0][vecs[i].o] = vecs[i].o0;
        observe[vecs[i].a][1][vecs[i].o] = vecs[i].o1;
      end
      if (vecs[i].use_model) begin
        model(vecs[i].a, vecs[i].o, vecs[i].init, trans, observe, eb, ee);
        vecs[i].exp_b = eb;
        vecs[i].exp_e = ee;
      end
      do_load(vecs[i].init);
      start(vecs[i].a, vecs[i].o, vecs[i].exp_b, vecs[i].exp_e);
      wait_done(40);
    end

    // Second start at E5 is ignored; a start in the cycle after valid is taken.
    set_tiger();
    do_load(16'h8000);
    v0 = valid_seen;
    start(2'd0, 1'b0, 16'hD99B, 1'b0);
    while (cyc < 21) begin
      if (cyc == 4) en_belief = 1'b1;
      if (cyc == 5) en_belief = 1'b0;
      tick();
    end
    check("single_valid", valid_seen - v0, 1);
    model(2'd0, 1'b0, 16'hD99B, trans, observe, eb, ee);
    start(2'd0, 1'b0, eb, ee);
    wait_done(40);
    check("ignored_start_none_left", valid_seen - v0, 2);

    // belief_load at E10 aborts the update.
    do_load(16'h8000);
    start(2'd0, 1'b0, 16'hD99B, 1'b0);
    while (cyc < 9) tick();
    belief_load = 1'b1;
    belief_init = 16'h4000;
    sb.delete();
    tick();
    belief_load = 1'b0;
    check("abort_belief", belief, 16'h4000);
    check("abort_busy", busy, 0);
    check("abort_valid", belief_valid, 0);
    v0 = valid_seen;
    repeat (25) tick();
    check("abort_no_valid", valid_seen - v0, 0);
    check("abort_belief_held", belief, 16'h4000);

    // en_belief together with belief_load is dropped.
    belief_load = 1'b1;
    belief_init = 16'h2222;
    en_belief   = 1'b1;
    tick();
    belief_load = 1'b0;
    en_belief   = 1'b0;
    check("load_en_belief", belief, 16'h2222);
    check("load_en_busy", busy, 0);
    v0 = valid_seen;
    repeat (25) tick();
    check("load_en_no_valid", valid_seen - v0, 0);

    // Asynchronous reset at E8 mid-update.
    do_load(16'h8000);
    start(2'd0, 1'b0, 16'hD99B, 1'b0);
    while (cyc < 7) tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_belief", belief, 16'h8000);
    check("rst_mid_valid", belief_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_seen;
    repeat (25) tick();
    check("rst_no_valid", valid_seen - v0, 0);
    check("rst_belief_held", belief, 16'h8000);
    start(2'd0, 1'b0, 16'hD99B, 1'b0);
    wait_done(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
